// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-mode PWM peripheral.
// Register indices, CTRL bit positions and the channel state enum.
package pwm_pkg;

    localparam int REGS_PER_CHAN = 4;

    localparam logic [1:0] PERIOD_IDX = 2'd0;
    localparam logic [1:0] DUTY_IDX   = 2'd1;
    localparam logic [1:0] CTRL_IDX   = 2'd2;
    localparam logic [1:0] COUNT_IDX  = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CENTER_BIT = 1;
    localparam int CTRL_INV_BIT    = 2;
    localparam int CTRL_WIDTH      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ch_state_e;

endpackage

// File: rtl/bus_protocol_if.sv
// Simple single-cycle peripheral bus.
// peripheral_vital: addr/wen/ren/wdata in; rdata/error/request_stall out.
interface bus_protocol_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wen;
    logic        ren;
    logic        error;
    logic        request_stall;

    modport peripheral_vital (
        input  addr, wen, ren, wdata,
        output rdata, error, request_stall
    );

    modport requester (
        output addr, wen, ren, wdata,
        input  rdata, error, request_stall
    );

endinterface

// File: rtl/pwm_mm_channel.sv
// One PWM channel: pending/active regs, IDLE/UP/DOWN FSM, counter,
// compare and period pulse.
// Ports: CLK, nRST, write strobes + data in; pending regs, CTRL,
// live count, registered pwm_out and period_pulse out.
module pwm_mm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  wr_period,
    input  logic                  wr_duty,
    input  logic                  wr_ctrl,
    input  logic [CNT_WIDTH-1:0]  wdata,
    input  logic [CTRL_WIDTH-1:0] wctrl,
    output logic [CNT_WIDTH-1:0]  pend_period,
    output logic [CNT_WIDTH-1:0]  pend_duty,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  pwm_out,
    output logic                  period_pulse
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] act_period;
    logic [CNT_WIDTH-1:0] act_duty;
    logic                 act_center;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nx;
    ch_state_e            state;
    ch_state_e            state_nx;
    logic                 boundary;
    logic                 load_act;
    logic                 raw;
    logic                 en;
    logic                 inv;

    assign en    = ctrl[CTRL_EN_BIT];
    assign inv   = ctrl[CTRL_INV_BIT];
    assign count = cnt;

    // IDLE with EN set is exactly the EN 0->1 transition edge.
    assign load_act = !en || (state == IDLE) || boundary;

    // A zero period parks the counter and forces the compare low.
    assign raw = (act_period != '0) && (cnt < act_duty);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        boundary = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = UP;
                    cnt_nx   = '0;
                end
                UP: begin
                    if (act_period == '0) begin
                        cnt_nx = '0;
                    end else if (!act_center) begin
                        if (cnt >= act_period - ONE) begin
                            cnt_nx   = '0;
                            boundary = 1'b1;
                        end else begin
                            cnt_nx = cnt + ONE;
                        end
                    end else if (cnt >= act_period) begin
                        // P=1 center has no DOWN leg: 0,1,0,1...
                        if (act_period == ONE) begin
                            cnt_nx   = '0;
                            boundary = 1'b1;
                        end else begin
                            state_nx = DOWN;
                            cnt_nx   = act_period - ONE;
                        end
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                DOWN: begin
                    if (cnt <= ONE) begin
                        state_nx = UP;
                        cnt_nx   = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_nx = cnt - ONE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pend_period  <= '0;
            pend_duty    <= '0;
            ctrl         <= '0;
            act_period   <= '0;
            act_duty     <= '0;
            act_center   <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            pwm_out      <= 1'b0;
            period_pulse <= 1'b0;
        end else begin
            if (wr_period) begin
                pend_period <= wdata;
            end
            if (wr_duty) begin
                pend_duty <= wdata;
            end
            if (wr_ctrl) begin
                ctrl <= wctrl;
            end
            // Uses pre-write pending values, so a write on a
            // boundary cycle waits for the following boundary.
            if (load_act) begin
                act_period <= pend_period;
                act_duty   <= pend_duty;
                act_center <= ctrl[CTRL_CENTER_BIT];
            end
            state        <= state_nx;
            cnt          <= cnt_nx;
            pwm_out      <= (state == IDLE) ? inv : (raw ^ inv);
            period_pulse <= boundary;
        end
    end

endmodule

// File: rtl/pwm_multimode.sv
// Multi-channel PWM peripheral: address decode, bus error, read mux.
// Ports: CLK, nRST, busif (peripheral_vital), pwm_out, period_pulse.
module pwm_multimode
    import pwm_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    CLK,
    input  logic                    nRST,
    bus_protocol_if.peripheral_vital busif,
    output logic [NUM_CHANNELS-1:0] pwm_out,
    output logic [NUM_CHANNELS-1:0] period_pulse
);

    localparam int LAST_ADDR = NUM_CHANNELS * REGS_PER_CHAN * 4 - 4;

    logic [CNT_WIDTH-1:0]  pend_period [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]  pend_duty   [NUM_CHANNELS];
    logic [CTRL_WIDTH-1:0] ctrl        [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]  count       [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] wr_period;
    logic [NUM_CHANNELS-1:0] wr_duty;
    logic [NUM_CHANNELS-1:0] wr_ctrl;

    logic [27:0] ch_idx;
    logic [1:0]  reg_idx;
    logic        addr_ok;
    logic        access;
    logic        err;
    logic        wr_ok;
    logic [31:0] rd_word;
    logic        unused_wdata;

    assign ch_idx  = busif.addr[31:4];
    assign reg_idx = busif.addr[3:2];
    assign access  = busif.wen || busif.ren;
    assign addr_ok = (busif.addr <= 32'(LAST_ADDR))
                  && (busif.addr[1:0] == 2'b00);

    assign err = access
              && (!addr_ok
              || (busif.wen && (reg_idx == COUNT_IDX)));

    assign wr_ok = busif.wen && !err;

    assign busif.error         = err;
    assign busif.request_stall = 1'b0;

    // Upper wdata bits beyond the counter width are ignored.
    assign unused_wdata = ^busif.wdata;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch_idx == 28'(i)) begin
                case (reg_idx)
                    PERIOD_IDX: rd_word = 32'(pend_period[i]);
                    DUTY_IDX:   rd_word = 32'(pend_duty[i]);
                    CTRL_IDX:   rd_word = 32'(ctrl[i]);
                    default:    rd_word = 32'(count[i]);
                endcase
            end
        end
    end

    assign busif.rdata = (busif.ren && !err) ? rd_word : '0;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic sel;
        assign sel = wr_ok && (ch_idx == 28'(i));

        assign wr_period[i] = sel && (reg_idx == PERIOD_IDX);
        assign wr_duty[i]   = sel && (reg_idx == DUTY_IDX);
        assign wr_ctrl[i]   = sel && (reg_idx == CTRL_IDX);

        pwm_mm_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .CLK          (CLK),
            .nRST         (nRST),
            .wr_period    (wr_period[i]),
            .wr_duty      (wr_duty[i]),
            .wr_ctrl      (wr_ctrl[i]),
            .wdata        (busif.wdata[CNT_WIDTH-1:0]),
            .wctrl        (busif.wdata[CTRL_WIDTH-1:0]),
            .pend_period  (pend_period[i]),
            .pend_duty    (pend_duty[i]),
            .ctrl         (ctrl[i]),
            .count        (count[i]),
            .pwm_out      (pwm_out[i]),
            .period_pulse (period_pulse[i])
        );
    end

endmodule
